// File: rtl/pfd_pkg.sv
// Shared definitions for the phase-frequency detector.
//   - pfd_state_e : detector state (idle, link leads, vco leads)
//   - default values for the SYNC_STAGES, MAX_PULSE and CNT_W parameters
//   - small decode helpers used by the top level
package pfd_pkg;

  localparam int unsigned SyncStagesDefault = 2;
  localparam int unsigned MaxPulseDefault   = 65535;
  localparam int unsigned CntWDefault       = 32;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StUp   = 2'b01,
    StDn   = 2'b10
  } pfd_state_e;

  // True while a phase-error pulse is being driven.
  function automatic logic in_pulse(input pfd_state_e st);
    return (st == StUp) || (st == StDn);
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Synchronizer and rising-edge detector for one asynchronous input.
//   clk   : system clock
//   nrst  : synchronous, active-high reset
//   din   : asynchronous input level
//   rise  : one-cycle pulse when the synchronized level goes 0 -> 1
//
// The edge event is combinational from the last synchronizer flop and the
// edge-history flop, so a rise first sampled at edge k is seen by the
// consumer at edge k + SYNC_STAGES.
module edge_sync
  import pfd_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SyncStagesDefault
) (
  input  logic clk,
  input  logic nrst,
  input  logic din,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  // Tracks how far valid post-reset samples have travelled down the chain.
  logic [SYNC_STAGES-1:0] vld_q, vld_d;
  logic                   prev_q;
  // Set once a valid low level has been seen after reset; an input that was
  // already high through reset must drop and rise again to count.
  logic                   arm_q, arm_d;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    vld_d  = {vld_q[SYNC_STAGES-2:0], 1'b1};
    arm_d  = arm_q | (vld_q[SYNC_STAGES-1] & ~synced);
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      sync_q <= '0;
      vld_q  <= '0;
      prev_q <= 1'b0;
      arm_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      vld_q  <= vld_d;
      prev_q <= synced;
      arm_q  <= arm_d;
    end
  end

  assign rise = arm_q & synced & ~prev_q;

endmodule

// File: rtl/pfd_unit.sv
// Phase-frequency detector with synchronized asynchronous inputs.
//   clk     : system clock, all state on rising edge
//   nrst    : synchronous, active-high reset
//   link    : reference clock (asynchronous)
//   vco     : feedback oscillator (asynchronous)
//   setting : bit0 = pulse active (up|dn), bit1 = direction (1 = vco leads)
//   up, dn  : registered phase-error pulses (never both high)
//   upb,dnb : registered complements of up and dn
//
// A pulse that outlives MAX_PULSE cycles is forced back to idle so a missed
// edge cannot lock the detector in one direction.
module pfd_unit
  import pfd_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SyncStagesDefault,
  parameter int unsigned MAX_PULSE   = MaxPulseDefault,
  parameter int unsigned CNT_W       = CntWDefault
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       link,
  input  logic       vco,
  output logic [1:0] setting,
  output logic       up,
  output logic       dn,
  output logic       upb,
  output logic       dnb
);

  // Age of the current pulse: cnt_q + 1 cycles have elapsed with it high.
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(MAX_PULSE - 1);

  logic link_rise;
  logic vco_rise;

  pfd_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             up_q, up_d;
  logic             dn_q, dn_d;
  logic             upb_q, dnb_q;
  logic             act_q, act_d;
  logic             timeout;

  edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_link_sync (
    .clk  (clk),
    .nrst (nrst),
    .din  (link),
    .rise (link_rise)
  );

  edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_vco_sync (
    .clk  (clk),
    .nrst (nrst),
    .din  (vco),
    .rise (vco_rise)
  );

  assign timeout = (cnt_q == CntLast);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        // Coincident edges mean zero phase error: no pulse.
        if (link_rise && !vco_rise) begin
          state_d = StUp;
          dir_d   = 1'b0;
        end else if (vco_rise && !link_rise) begin
          state_d = StDn;
          dir_d   = 1'b1;
        end
      end
      StUp: begin
        cnt_d = cnt_q + 1'b1;
        // A lone link edge means the feedback is slow: keep pulsing.
        if ((vco_rise && !link_rise) || timeout) begin
          state_d = StIdle;
        end
      end
      StDn: begin
        cnt_d = cnt_q + 1'b1;
        if ((link_rise && !vco_rise) || timeout) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it.
  always_comb begin
    up_d  = (state_d == StUp);
    dn_d  = (state_d == StDn);
    act_d = in_pulse(state_d);
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
      upb_q   <= 1'b1;
      dnb_q   <= 1'b1;
      act_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
      upb_q   <= ~up_d;
      dnb_q   <= ~dn_d;
      act_q   <= act_d;
    end
  end

  assign up      = up_q;
  assign dn      = dn_q;
  assign upb     = upb_q;
  assign dnb     = dnb_q;
  assign setting = {dir_q, act_q};

endmodule

// File: tb/tb_pfd_unit.sv
// Self-checking bench for pfd_unit. A timestamp-based reference model turns
// per-cycle input samples into expected outputs: edges are rises between
// consecutive post-reset samples, seen two cycles later; a pulse belongs to
// whichever input rose first and ends on the other input's edge or after
// MaxPulse cycles.
module tb_pfd_unit;

  localparam int unsigned MaxPulse = 20;

  logic       clk = 1'b0;
  logic       nrst = 1'b1;
  logic       link = 1'b0;
  logic       vco = 1'b0;
  logic [1:0] setting;
  logic       up, dn, upb, dnb;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  bit   lhist[$];
  bit   vhist[$];
  int   owner = 0;  // 0: none, 1: link leads, 2: vco leads
  int   start = 0;
  int   cyc = 0;
  bit   exp_dir = 1'b0;
  logic [5:0] exp_o = 6'b001100;

  pfd_unit #(
    .SYNC_STAGES(2),
    .MAX_PULSE  (MaxPulse),
    .CNT_W      (32)
  ) dut (
    .clk     (clk),
    .nrst    (nrst),
    .link    (link),
    .vco     (vco),
    .setting (setting),
    .up      (up),
    .dn      (dn),
    .upb     (upb),
    .dnb     (dnb)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, n_vec=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  // Drive one cycle of inputs, advance past the edge and update the model.
  task automatic tick(input bit l, input bit v);
    bit le, ve;
    int i;
    link = l;
    vco  = v;
    @(posedge clk);
    #1;
    cyc++;
    if (nrst) begin
      lhist.delete();
      vhist.delete();
      owner   = 0;
      exp_dir = 1'b0;
    end else begin
      lhist.push_back(l);
      vhist.push_back(v);
      le = 1'b0;
      ve = 1'b0;
      i  = lhist.size() - 3;
      if (i >= 1) begin
        le = lhist[i] && !lhist[i-1];
        ve = vhist[i] && !vhist[i-1];
      end
      if (owner != 0 && (cyc - start) >= MaxPulse) begin
        owner = 0;
      end else if (owner == 0) begin
        if (le && !ve) begin
          owner = 1; start = cyc; exp_dir = 1'b0;
        end else if (ve && !le) begin
          owner = 2; start = cyc; exp_dir = 1'b1;
        end
      end else if (owner == 1 && ve && !le) begin
        owner = 0;
      end else if (owner == 2 && le && !ve) begin
        owner = 0;
      end
    end
    exp_o = {owner == 1, owner == 2, owner != 1, owner != 2, exp_dir, owner != 0};
  endtask

  task automatic test_reset();
    nrst = 1'b1;
    repeat (5) begin
      tick(1'b1, 1'b1);
      n_vec++;
      if ({up, dn, upb, dnb, setting} !== exp_o) begin
        n_err++;
        $display("FAIL reset_hold cyc=%0d got=%b exp=%b", cyc, {up, dn, upb, dnb, setting}, exp_o);
      end
    end
    n_vec++;
    if ({up, dn, upb, dnb, setting} !== 6'b001100) begin
      n_err++;
      $display("FAIL reset_values got=%b exp=001100", {up, dn, upb, dnb, setting});
    end
    nrst = 1'b0;
    repeat (8) begin
      tick(1'b1, 1'b1);
      n_vec++;
      if ({up, dn, upb, dnb, setting} !== exp_o) begin
        n_err++;
        $display("FAIL reset_release cyc=%0d got=%b exp=%b", cyc, {up, dn, upb, dnb, setting}, exp_o);
      end
      n_vec++;
      if (up !== 1'b0 || dn !== 1'b0) begin
        n_err++;
        $display("FAIL reset_no_pulse cyc=%0d got up=%b dn=%b exp 0 0", cyc, up, dn);
      end
    end
    repeat (6) begin
      tick(1'b0, 1'b0);
      n_vec++;
      if ({up, dn, upb, dnb, setting} !== exp_o) begin
        n_err++;
        $display("FAIL reset_low cyc=%0d got=%b exp=%b", cyc, {up, dn, upb, dnb, setting}, exp_o);
      end
    end
  endtask

  // One input rises `lead` cycles before the other.
  task automatic test_lead(input bit link_first, input int lead);
    int  len = 0;
    bit  other = 1'b0;
    repeat (lead) begin
      tick(link_first, !link_first);
      n_vec++;
      if ({up, dn, upb, dnb, setting} !== exp_o) begin
        n_err++;
        $display("FAIL lead_first cyc=%0d got=%b exp=%b", cyc, {up, dn, upb, dnb, setting}, exp_o);
      end
      len += link_first ? int'(up) : int'(dn);
      other |= link_first ? dn : up;
    end
    repeat (lead + 8) begin
      tick(1'b1, 1'b1);
      n_vec++;
      if ({up, dn, upb, dnb, setting} !== exp_o) begin
        n_err++;
        $display("FAIL lead_both cyc=%0d got=%b exp=%b", cyc, {up, dn, upb, dnb, setting}, exp_o);
      end
      len += link_first ? int'(up) : int'(dn);
      other |= link_first ? dn : up;
    end
    n_vec++;
    if (len != lead || other) begin
      n_err++;
      $display("FAIL lead_len link_first=%0d got len=%0d other=%0d exp len=%0d other=0",
               link_first, len, other, lead);
    end
    n_vec++;
    if (setting !== {!link_first, 1'b0}) begin
      n_err++;
      $display("FAIL lead_dir_hold got=%b exp=%b", setting, {!link_first, 1'b0});
    end
    repeat (6) begin
      tick(1'b0, 1'b0);
      n_vec++;
      if ({up, dn, upb, dnb, setting} !== exp_o) begin
        n_err++;
        $display("FAIL lead_low cyc=%0d got=%b exp=%b", cyc, {up, dn, upb, dnb, setting}, exp_o);
      end
    end
  endtask

  task automatic test_same_edge();
    repeat (12) begin
      tick(1'b1, 1'b1);
      n_vec++;
      if ({up, dn, upb, dnb, setting} !== exp_o) begin
        n_err++;
        $display("FAIL same_edge cyc=%0d got=%b exp=%b", cyc, {up, dn, upb, dnb, setting}, exp_o);
      end
      n_vec++;
      if (up !== 1'b0 || dn !== 1'b0 || setting[0] !== 1'b0) begin
        n_err++;
        $display("FAIL same_edge_quiet cyc=%0d got up=%b dn=%b act=%b exp 0 0 0",
                 cyc, up, dn, setting[0]);
      end
    end
    repeat (6) tick(1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    int  run = 0;
    int  first_run = -1;
    bit  reassert = 1'b0;
    bit  prev_up = 1'b0;
    for (int t = 0; t < 64; t++) begin
      tick((t % 8) < 4, 1'b0);
      n_vec++;
      if ({up, dn, upb, dnb, setting} !== exp_o) begin
        n_err++;
        $display("FAIL timeout cyc=%0d got=%b exp=%b", cyc, {up, dn, upb, dnb, setting}, exp_o);
      end
      if (up) run++;
      if (prev_up && !up && first_run < 0) first_run = run;
      if (!prev_up && up && first_run >= 0) reassert = 1'b1;
      prev_up = up;
    end
    n_vec++;
    if (first_run != int'(MaxPulse) || !reassert) begin
      n_err++;
      $display("FAIL timeout_len got run=%0d reassert=%0d exp run=%0d reassert=1",
               first_run, reassert, MaxPulse);
    end
    repeat (25) tick(1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_pulse();
    int ups = 0;
    for (int t = 0; t < 12 && ups < 3; t++) begin
      tick(1'b1, 1'b0);
      if (up) ups++;
    end
    n_vec++;
    if (ups != 3) begin
      n_err++;
      $display("FAIL mid_pulse_start got up_cycles=%0d exp 3", ups);
    end
    nrst = 1'b1;
    tick(1'b1, 1'b0);
    n_vec++;
    if (up !== 1'b0 || dn !== 1'b0 || setting !== 2'b00) begin
      n_err++;
      $display("FAIL mid_pulse_reset got up=%b dn=%b setting=%b exp 0 0 00", up, dn, setting);
    end
    nrst = 1'b0;
    repeat (6) begin
      tick(1'b1, 1'b0);
      n_vec++;
      if ({up, dn, upb, dnb, setting} !== exp_o || up !== 1'b0) begin
        n_err++;
        $display("FAIL mid_pulse_release cyc=%0d got=%b exp=%b", cyc, {up, dn, upb, dnb, setting}, exp_o);
      end
    end
    repeat (4) tick(1'b0, 1'b0);
    test_lead(1'b1, 5);
  endtask

  task automatic test_random();
    bit l = 1'b0;
    bit v = 1'b0;
    for (int t = 0; t < 800; t++) begin
      if ($urandom_range(0, 5) == 0) l = !l;
      if ($urandom_range(0, 5) == 0) v = !v;
      nrst = ($urandom_range(0, 199) == 0);
      tick(l, v);
      n_vec++;
      if ({up, dn, upb, dnb, setting} !== exp_o) begin
        n_err++;
        $display("FAIL random cyc=%0d got=%b exp=%b", cyc, {up, dn, upb, dnb, setting}, exp_o);
      end
    end
    nrst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lead(1'b1, 10);
    test_lead(1'b0, 7);
    test_same_edge();
    test_timeout();
    test_reset_mid_pulse();
    test_lead(1'b0, 3);
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
